// File: rtl/nasti_lite_io_arbiter.sv
// Round-robin arbiter sharing one NASTI-Lite IO slave among NUM_MASTERS requesters.
// Read and write paths run independent FSMs, each with one outstanding transaction.
module nasti_lite_io_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  // master write address / data / response
  input  logic [NUM_MASTERS-1:0]              i_m_aw_valid,
  output logic [NUM_MASTERS-1:0]              o_m_aw_ready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   i_m_aw_addr,
  input  logic [NUM_MASTERS*3-1:0]            i_m_aw_prot,
  input  logic [NUM_MASTERS-1:0]              i_m_w_valid,
  output logic [NUM_MASTERS-1:0]              o_m_w_ready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   i_m_w_data,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] i_m_w_strb,
  output logic [NUM_MASTERS-1:0]              o_m_b_valid,
  input  logic [NUM_MASTERS-1:0]              i_m_b_ready,
  output logic [1:0]                          o_m_b_resp,
  // master read address / data
  input  logic [NUM_MASTERS-1:0]              i_m_ar_valid,
  output logic [NUM_MASTERS-1:0]              o_m_ar_ready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   i_m_ar_addr,
  input  logic [NUM_MASTERS*3-1:0]            i_m_ar_prot,
  output logic [NUM_MASTERS-1:0]              o_m_r_valid,
  input  logic [NUM_MASTERS-1:0]              i_m_r_ready,
  output logic [DATA_WIDTH-1:0]               o_m_r_data,
  output logic [1:0]                          o_m_r_resp,
  // slave write channels
  output logic                                o_s_aw_valid,
  input  logic                                i_s_aw_ready,
  output logic [ADDR_WIDTH-1:0]               o_s_aw_addr,
  output logic [2:0]                          o_s_aw_prot,
  output logic                                o_s_w_valid,
  input  logic                                i_s_w_ready,
  output logic [DATA_WIDTH-1:0]               o_s_w_data,
  output logic [DATA_WIDTH/8-1:0]             o_s_w_strb,
  input  logic                                i_s_b_valid,
  output logic                                o_s_b_ready,
  input  logic [1:0]                          i_s_b_resp,
  // slave read channels
  output logic                                o_s_ar_valid,
  input  logic                                i_s_ar_ready,
  output logic [ADDR_WIDTH-1:0]               o_s_ar_addr,
  output logic [2:0]                          o_s_ar_prot,
  input  logic                                i_s_r_valid,
  output logic                                o_s_r_ready,
  input  logic [DATA_WIDTH-1:0]               i_s_r_data,
  input  logic [1:0]                          i_s_r_resp
);

  localparam int N  = int'(NUM_MASTERS);
  localparam int AW = int'(ADDR_WIDTH);
  localparam int DW = int'(DATA_WIDTH);
  localparam int SW = DW / 8;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {WIdle, WAddr, WResp} wstate_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData} rstate_e;

  wstate_e         r_wstate, w_wstate_nxt;
  rstate_e         r_rstate, w_rstate_nxt;
  logic [IW-1:0]   r_wgnt, w_wgnt_nxt, r_wptr, w_wptr_nxt;
  logic [IW-1:0]   r_rgnt, w_rgnt_nxt, r_rptr, w_rptr_nxt;
  logic            r_aw_done, w_aw_done_nxt, r_w_done, w_w_done_nxt;
  logic            w_aw_hs, w_w_hs;
  logic [N-1:0]    w_weligible;

  // Highest priority goes to the first requester after ptr, wrapping around.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] ptr);
    int idx;
    rr_pick = ptr;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) rr_pick = IW'(idx);
    end
  endfunction

  assign w_weligible = i_m_aw_valid & i_m_w_valid;
  assign o_s_aw_addr = i_m_aw_addr[int'(r_wgnt)*AW +: AW];
  assign o_s_aw_prot = i_m_aw_prot[int'(r_wgnt)*3 +: 3];
  assign o_s_w_data  = i_m_w_data[int'(r_wgnt)*DW +: DW];
  assign o_s_w_strb  = i_m_w_strb[int'(r_wgnt)*SW +: SW];
  assign o_s_ar_addr = i_m_ar_addr[int'(r_rgnt)*AW +: AW];
  assign o_s_ar_prot = i_m_ar_prot[int'(r_rgnt)*3 +: 3];
  assign o_m_b_resp  = i_s_b_resp;
  assign o_m_r_data  = i_s_r_data;
  assign o_m_r_resp  = i_s_r_resp;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wstate  <= WIdle;
      r_rstate  <= RIdle;
      r_wgnt    <= '0;
      r_rgnt    <= '0;
      r_wptr    <= IW'(N - 1);
      r_rptr    <= IW'(N - 1);
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_rstate  <= w_rstate_nxt;
      r_wgnt    <= w_wgnt_nxt;
      r_rgnt    <= w_rgnt_nxt;
      r_wptr    <= w_wptr_nxt;
      r_rptr    <= w_rptr_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_wgnt_nxt    = r_wgnt;
    w_wptr_nxt    = r_wptr;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_aw_hs       = 1'b0;
    w_w_hs        = 1'b0;
    o_s_aw_valid  = 1'b0;
    o_s_w_valid   = 1'b0;
    o_s_b_ready   = 1'b0;
    o_m_aw_ready  = '0;
    o_m_w_ready   = '0;
    o_m_b_valid   = '0;
    unique case (r_wstate)
      WIdle: begin
        if (|w_weligible) begin
          w_wgnt_nxt   = rr_pick(w_weligible, r_wptr);
          w_wstate_nxt = WAddr;
        end
      end
      WAddr: begin
        o_s_aw_valid         = i_m_aw_valid[r_wgnt] & ~r_aw_done;
        o_s_w_valid          = i_m_w_valid[r_wgnt] & ~r_w_done;
        o_m_aw_ready[r_wgnt] = i_s_aw_ready & ~r_aw_done;
        o_m_w_ready[r_wgnt]  = i_s_w_ready & ~r_w_done;
        w_aw_hs              = o_s_aw_valid & i_s_aw_ready;
        w_w_hs               = o_s_w_valid & i_s_w_ready;
        // Done flags stop re-issue once a channel has handshaken.
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
          w_wstate_nxt  = WResp;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end else begin
          w_aw_done_nxt = r_aw_done | w_aw_hs;
          w_w_done_nxt  = r_w_done | w_w_hs;
        end
      end
      WResp: begin
        o_m_b_valid[r_wgnt] = i_s_b_valid;
        o_s_b_ready         = i_m_b_ready[r_wgnt];
        if (i_s_b_valid & i_m_b_ready[r_wgnt]) begin
          w_wstate_nxt = WIdle;
          w_wptr_nxt   = r_wgnt;
        end
      end
      default: w_wstate_nxt = WIdle;
    endcase
    // Keep every handshake output quiet while reset is held.
    if (i_rst) begin
      o_s_aw_valid = 1'b0;
      o_s_w_valid  = 1'b0;
      o_s_b_ready  = 1'b0;
      o_m_aw_ready = '0;
      o_m_w_ready  = '0;
      o_m_b_valid  = '0;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rgnt_nxt   = r_rgnt;
    w_rptr_nxt   = r_rptr;
    o_s_ar_valid = 1'b0;
    o_s_r_ready  = 1'b0;
    o_m_ar_ready = '0;
    o_m_r_valid  = '0;
    unique case (r_rstate)
      RIdle: begin
        if (|i_m_ar_valid) begin
          w_rgnt_nxt   = rr_pick(i_m_ar_valid, r_rptr);
          w_rstate_nxt = RAddr;
        end
      end
      RAddr: begin
        o_s_ar_valid         = i_m_ar_valid[r_rgnt];
        o_m_ar_ready[r_rgnt] = i_s_ar_ready;
        if (i_m_ar_valid[r_rgnt] & i_s_ar_ready) w_rstate_nxt = RData;
      end
      RData: begin
        o_m_r_valid[r_rgnt] = i_s_r_valid;
        o_s_r_ready         = i_m_r_ready[r_rgnt];
        if (i_s_r_valid & i_m_r_ready[r_rgnt]) begin
          w_rstate_nxt = RIdle;
          w_rptr_nxt   = r_rgnt;
        end
      end
      default: w_rstate_nxt = RIdle;
    endcase
    if (i_rst) begin
      o_s_ar_valid = 1'b0;
      o_s_r_ready  = 1'b0;
      o_m_ar_ready = '0;
      o_m_r_valid  = '0;
    end
  end

endmodule
